// File: rtl/serial_cmp_ctrl_if.sv
// Handshake/result bundle for serial_cmp_ctrl: operands and start in, status and verdict out.
interface serial_cmp_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, a, b,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first unsigned magnitude comparator built around one priority comparator cell.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit decides the result.

module prio_cmp_cell (
  input  logic a,
  input  logic b,
  input  logic p1,
  input  logic p2,
  output logic l1,
  output logic l2,
  output logic l3
);
  // p1/p2 carry an earlier verdict; once set, lower bits cannot override it.
  assign l1 = p1 | (~p2 & ~a &  b);
  assign l2 = p2 | (~p1 &  a & ~b);
  assign l3 = ~(l1 | l2);
endmodule

module serial_cmp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_cmp_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_lt_f;
  logic             r_gt_f;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;
  logic             w_l1;
  logic             w_l2;
  logic             w_l3;
  logic             w_last;
  logic             w_finish;

  prio_cmp_cell u_cell (
    .a  (r_a[r_idx]),
    .b  (r_b[r_idx]),
    .p1 (r_lt_f),
    .p2 (r_gt_f),
    .l1 (w_l1),
    .l2 (w_l2),
    .l3 (w_l3)
  );

  assign w_last = (r_idx == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_finish = w_last | w_l1 | w_l2;
`else
  assign w_finish = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_finish)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= IW'(WIDTH - 1);
      r_lt_f <= 1'b0;
      r_gt_f <= 1'b0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_idx  <= IW'(WIDTH - 1);
            r_lt_f <= 1'b0;
            r_gt_f <= 1'b0;
          end
        end
        S_RUN: begin
          r_lt_f <= w_l1;
          r_gt_f <= w_l2;
          r_idx  <= r_idx - IW'(1);
          // Result registers take the cell outputs directly so DONE shows the final verdict.
          if (w_finish) begin
            r_lt <= w_l1;
            r_gt <= w_l2;
            r_eq <= w_l3;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.lt   = r_lt;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Randomized self-checking bench for serial_cmp_ctrl at WIDTH=8 and WIDTH=32 against an arithmetic reference.
module tb_serial_cmp_ctrl;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int unsigned errors;
  int unsigned checks;
  int unsigned n_done8, n_done32;
  int unsigned n_exp8, n_exp32;

  serial_cmp_ctrl_if #(.WIDTH(8))  if8 ();
  serial_cmp_ctrl_if #(.WIDTH(32)) if32 ();

  serial_cmp_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_cmp_ctrl #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if8.done)  n_done8++;
    if (if32.done) n_done32++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Cycles spent in RUN: the whole word, or up to the first differing bit from the MSB.
  function automatic int unsigned exp_lat(input int unsigned w, input logic [31:0] a, input logic [31:0] b);
    if (EARLY) begin
      for (int i = int'(w) - 1; i >= 0; i--)
        if (a[i] != b[i]) return w - unsigned'(i);
    end
    return w;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    return {a < b, a > b, a == b};
  endfunction

  function automatic logic get_done(input bit w32);
    return w32 ? if32.done : if8.done;
  endfunction

  function automatic logic get_busy(input bit w32);
    return w32 ? if32.busy : if8.busy;
  endfunction

  function automatic logic [2:0] get_res(input bit w32);
    return w32 ? {if32.lt, if32.gt, if32.eq} : {if8.lt, if8.gt, if8.eq};
  endfunction

  task automatic set_in(input bit w32, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w32) begin
      if32.start = s; if32.a = a; if32.b = b;
    end else begin
      if8.start = s; if8.a = a[7:0]; if8.b = b[7:0];
    end
  endtask

  // Called #1 after the edge that captured a/b; also pokes start once mid-run to confirm it is ignored.
  task automatic finish_op(input bit w32, input logic [31:0] a_in, input logic [31:0] b_in, input string tag);
    int unsigned w, l_exp, k;
    logic [31:0] a, b;
    logic [2:0] exp_res;
    w = w32 ? 32 : 8;
    a = w32 ? a_in : (a_in & 32'hFF);
    b = w32 ? b_in : (b_in & 32'hFF);
    l_exp = exp_lat(w, a, b);
    exp_res = ref_cmp(a, b);
    if (w32) n_exp32++; else n_exp8++;
    check({tag, "_busy"}, {31'd0, get_busy(w32)}, 32'd1);
    set_in(w32, 1'b1, $urandom, $urandom);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) set_in(w32, 1'b0, $urandom, $urandom);
    end while (!get_done(w32) && k < 200);
    check({tag, "_lat"}, k, l_exp);
    check({tag, "_res"}, {29'd0, get_res(w32)}, {29'd0, exp_res});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, get_done(w32), get_busy(w32)}, 32'd0);
    check({tag, "_hold"}, {29'd0, get_res(w32)}, {29'd0, exp_res});
  endtask

  task automatic op(input bit w32, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    set_in(w32, 1'b1, a, b);
    @(posedge clk); #1;
    finish_op(w32, a, b, tag);
  endtask

  // start held high across two operations; operands switch right after each capture.
  task automatic b2b();
    logic [31:0] a1, b1, a2, b2;
    int unsigned l1, l2, k, t1, t2;
    a1 = 32'h10; b1 = 32'h20; a2 = 32'hF0; b2 = 32'h0F;
    l1 = exp_lat(8, a1, b1);
    l2 = exp_lat(8, a2, b2);
    @(negedge clk);
    set_in(1'b0, 1'b1, a1, b1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, a2, b2);
    t1 = 0; t2 = 0; k = 0;
    while (t2 == 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (if8.done) begin
        if (t1 == 0) begin
          t1 = k;
          check("b2b_res1", {29'd0, get_res(1'b0)}, {29'd0, ref_cmp(a1, b1)});
        end else begin
          t2 = k;
          check("b2b_res2", {29'd0, get_res(1'b0)}, {29'd0, ref_cmp(a2, b2)});
        end
      end
      if (k == l1 + 2) set_in(1'b0, 1'b0, 32'h55, 32'hAA);
    end
    n_exp8 += 2;
    check("b2b_lat1", t1, l1);
    check("b2b_gap", t2 - t1 - 1, l2 + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_idle", {31'd0, get_busy(1'b0)}, 32'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'hC3, 32'hC3);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 32'h00, 32'hFF);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid8", {27'd0, if8.busy, if8.done, if8.lt, if8.gt, if8.eq}, 32'd0);
    check("rst_mid32", {27'd0, if32.busy, if32.done, if32.lt, if32.gt, if32.eq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 32'h3C, 32'h3D);
    @(posedge clk); #1;
    finish_op(1'b0, 32'h3C, 32'h3D, "post_rst");
  endtask

  initial begin
    errors = 0; checks = 0;
    n_done8 = 0; n_done32 = 0; n_exp8 = 0; n_exp32 = 0;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    set_in(1'b1, 1'b0, 32'h0, 32'h0);
    #7;
    check("rst8", {27'd0, if8.busy, if8.done, if8.lt, if8.gt, if8.eq}, 32'd0);
    check("rst32", {27'd0, if32.busy, if32.done, if32.lt, if32.gt, if32.eq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 32'h5A, 32'h5A, "eq5A");
    op(1'b0, 32'h80, 32'h7F, "gt80");
    op(1'b0, 32'h03, 32'h04, "lt03");
    op(1'b0, 32'h00, 32'hFF, "lt00");
    op(1'b0, 32'hFF, 32'hFF, "eqFF");
    op(1'b0, 32'h01, 32'h00, "gt01");
    op(1'b1, 32'h0, 32'h0, "eq32z");
    op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "gt32lsb");
    op(1'b1, 32'h1, 32'h8000_0000, "lt32msb");

    b2b();
    reset_mid();

    for (int unsigned n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 7));
        default: rb = $urandom_range(0, 255);
      endcase
      op(1'b0, ra, rb, "rnd8");
    end

    for (int unsigned n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      op(1'b1, ra, rb, "rnd32");
    end

    repeat (3) @(posedge clk);
    #1;
    check("done_cnt8", n_done8, n_exp8);
    check("done_cnt32", n_done32, n_exp32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
